// File: rtl/ray_tri_intersect_iter.sv
// Ray / triangle intersection with Cramer's rule and one shared iterative divider.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, o_ready    request handshake (accepted only in IDLE)
//   i_triangle          corners [2:0] x components [2:0], signed Q(W-FRAC).FRAC
//   i_ray               [1] origin E, [0] direction D
//   o_valid, i_ready    result handshake (held in DONE until i_ready)
//   o_hit, o_invalid    hit flag, degenerate/overflow flag
//   o_a, o_b, o_t       barycentric a, b and distance t (0 when not computed)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// DET     | compute and register the four determinants
// DIV_A   | a = det_a / coef (W cycles), early reject when a outside [0,ONE]
// DIV_B   | b = det_b / coef (W cycles)
// DIV_T   | t = det_t / coef (W cycles)
// CHECK   | evaluate hit / invalid flags
// DONE    | result presented until i_ready
module ray_tri_intersect_iter #(
    parameter int                W     = 32,
    parameter int                FRAC  = 16,
    parameter logic signed [W-1:0] MIN_T = '0,
    parameter logic signed [W-1:0] MAX_T = {1'b0, {(W-1){1'b1}}}
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic signed [2:0][2:0][W-1:0]   i_triangle,
    input  logic signed [1:0][2:0][W-1:0]   i_ray,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_hit,
    output logic                            o_invalid,
    output logic signed [W-1:0]             o_a,
    output logic signed [W-1:0]             o_b,
    output logic signed [W-1:0]             o_t
);
    localparam int DETW = 3*W + 6;      // exact width of a 3x3 determinant of W+1 bit terms
    localparam int DW   = 2*W + FRAC;   // divider remainder / shifted divisor width
    localparam int CW   = $clog2(W) + 1;
    localparam logic signed [W:0]   ONE_X = (W+1)'(1) << FRAC;
    localparam logic signed [W-1:0] ONE_W = ONE_X[W-1:0];

    typedef enum logic [2:0] {S_IDLE, S_DET, S_DIV_A, S_DIV_B, S_DIV_T, S_CHECK, S_DONE} state_t;
    state_t state, state_nx;

    logic signed [W-1:0] c_r [3][3];
    logic signed [W-1:0] e_r [3];
    logic signed [W-1:0] d_r [3];
    logic signed [W:0]   t1 [3], t2 [3], r [3], n [3];
    logic signed [DETW-1:0] raw [4], sh [4];
    logic signed [W-1:0] det_s [4];
    logic [3:0]          det_ovf;
    logic                coef_zero;

    logic signed [W-1:0] coef_r, dtb_r, dtt_r;
    logic                degen, ovf;
    logic [DW-1:0]       rem, dsr;
    logic [W-2:0]        quo;
    logic [CW-1:0]       cnt;
    logic                q_neg, ge, last, div_ovf, reject_a;
    logic [W-1:0]        q_fin;
    logic signed [W-1:0] q_sgn;
    logic signed [W:0]   ab_sum;
    logic                inv, hit_cond;

    function automatic logic signed [DETW-1:0] sx(input logic signed [W:0] v);
        return {{(DETW-W-1){v[W]}}, v};
    endfunction

    // Columns a, b, c; cofactor expansion along the x row.
    function automatic logic signed [DETW-1:0] det3(input logic signed [W:0] a [3],
                                                    input logic signed [W:0] b [3],
                                                    input logic signed [W:0] c [3]);
        logic signed [DETW-1:0] ax, ay, az, bx, by, bz, cx, cy, cz;
        ax = sx(a[0]); ay = sx(a[1]); az = sx(a[2]);
        bx = sx(b[0]); by = sx(b[1]); bz = sx(b[2]);
        cx = sx(c[0]); cy = sx(c[1]); cz = sx(c[2]);
        return ax*(by*cz - bz*cy) - bx*(ay*cz - az*cy) + cx*(ay*bz - az*by);
    endfunction

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        logic [W-1:0] m;
        m = v[W-1] ? -v : v;
        return m;
    endfunction

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            t1[j] = {c_r[1][j][W-1], c_r[1][j]} - {c_r[0][j][W-1], c_r[0][j]};
            t2[j] = {c_r[2][j][W-1], c_r[2][j]} - {c_r[0][j][W-1], c_r[0][j]};
            r[j]  = {e_r[j][W-1], e_r[j]} - {c_r[0][j][W-1], c_r[0][j]};
            n[j]  = -{d_r[j][W-1], d_r[j]};
        end
        raw[0] = det3(t1, t2, n);
        raw[1] = det3(r,  t2, n);
        raw[2] = det3(t1, r,  n);
        raw[3] = det3(t1, t2, r);
        for (int k = 0; k < 4; k++) begin
            sh[k]      = raw[k] >>> (2*FRAC);
            det_s[k]   = sh[k][W-1:0];
            // representable only when everything above the sign bit is sign extension
            det_ovf[k] = !((&sh[k][DETW-1:W-1]) || !(|sh[k][DETW-1:W-1]));
        end
        coef_zero = (det_s[0] == '0);
    end

    // One restoring step per cycle; the first step decides bit W-1, which flags overflow.
    always_comb begin
        ge       = (rem >= dsr);
        q_fin    = {quo, ge};
        div_ovf  = q_fin[W-1];
        q_sgn    = q_neg ? -q_fin : q_fin;
        last     = (cnt == '0);
        reject_a = div_ovf || (q_sgn < 0) || (q_sgn > ONE_W);
        ab_sum   = {o_a[W-1], o_a} + {o_b[W-1], o_b};
        inv      = degen || ovf;
        hit_cond = (o_a >= 0) && (o_b >= 0) && (ab_sum <= ONE_X) &&
                   (o_t >= MIN_T) && (o_t <= MAX_T);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (i_valid) state_nx = S_DET;
            S_DET:   state_nx = (coef_zero || (|det_ovf)) ? S_CHECK : S_DIV_A;
            S_DIV_A: if (last) state_nx = reject_a ? S_CHECK : S_DIV_B;
            S_DIV_B: if (last) state_nx = S_DIV_T;
            S_DIV_T: if (last) state_nx = S_CHECK;
            S_CHECK: state_nx = S_DONE;
            S_DONE:  if (i_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
        o_valid = (state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) c_r[k][j] <= '0;
                e_r[k] <= '0;
                d_r[k] <= '0;
            end
            coef_r <= '0; dtb_r <= '0; dtt_r <= '0;
            degen <= 1'b0; ovf <= 1'b0; q_neg <= 1'b0;
            rem <= '0; dsr <= '0; quo <= '0; cnt <= '0;
            o_hit <= 1'b0; o_invalid <= 1'b0;
            o_a <= '0; o_b <= '0; o_t <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (i_valid) begin
                    for (int j = 0; j < 3; j++) begin
                        for (int k = 0; k < 3; k++) c_r[k][j] <= $signed(i_triangle[k][j]);
                        e_r[j] <= $signed(i_ray[1][j]);
                        d_r[j] <= $signed(i_ray[0][j]);
                    end
                    o_a <= '0; o_b <= '0; o_t <= '0;
                    o_hit <= 1'b0; o_invalid <= 1'b0;
                    ovf <= 1'b0;
                end
                S_DET: begin
                    coef_r <= det_s[0];
                    dtb_r  <= det_s[2];
                    dtt_r  <= det_s[3];
                    degen  <= coef_zero;
                    ovf    <= |det_ovf;
                    rem    <= {{(DW-W){1'b0}}, mag(det_s[1])} << FRAC;
                    dsr    <= {{(DW-W){1'b0}}, mag(det_s[0])} << (W-1);
                    q_neg  <= det_s[1][W-1] ^ det_s[0][W-1];
                    cnt    <= CW'(W-1);
                end
                S_DIV_A, S_DIV_B, S_DIV_T: begin
                    rem <= ge ? rem - dsr : rem;
                    dsr <= dsr >> 1;
                    quo <= q_fin[W-2:0];
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        if (div_ovf)                ovf <= 1'b1;
                        else if (state == S_DIV_A)  o_a <= q_sgn;
                        else if (state == S_DIV_B)  o_b <= q_sgn;
                        else                        o_t <= q_sgn;
                        // preload the next quotient; unused after DIV_T
                        rem   <= {{(DW-W){1'b0}}, mag((state == S_DIV_A) ? dtb_r : dtt_r)} << FRAC;
                        dsr   <= {{(DW-W){1'b0}}, mag(coef_r)} << (W-1);
                        q_neg <= ((state == S_DIV_A) ? dtb_r[W-1] : dtt_r[W-1]) ^ coef_r[W-1];
                        cnt   <= CW'(W-1);
                    end
                end
                S_CHECK: begin
                    o_invalid <= inv;
                    o_hit     <= !inv && hit_cond;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_tri_intersect_iter.sv
// Scoreboard bench for ray_tri_intersect_iter: directed cases plus randomized rays
// checked against a wide-integer Cramer's-rule reference model.
module tb_ray_tri_intersect_iter;
    localparam int W = 32;
    localparam int ONE = 65536;

    logic clk = 1'b0;
    logic rst, i_valid, i_ready;
    logic o_ready, o_valid, o_hit, o_invalid;
    logic signed [2:0][2:0][31:0] tri_i;
    logic signed [1:0][2:0][31:0] ray_i;
    logic signed [31:0] o_a, o_b, o_t;

    always #5 clk = ~clk;

    ray_tri_intersect_iter dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_triangle(tri_i), .i_ray(ray_i), .o_valid(o_valid), .i_ready(i_ready),
        .o_hit(o_hit), .o_invalid(o_invalid), .o_a(o_a), .o_b(o_b), .o_t(o_t)
    );

    typedef logic signed [127:0] big_t;
    typedef struct {
        bit hit; bit inv; bit chkv;
        int a; int b; int t; int lat; int acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Rule of Sarrus on column vectors a, b, c.
    function automatic big_t det_cols(input big_t a[3], input big_t b[3], input big_t c[3]);
        return a[0]*b[1]*c[2] + b[0]*c[1]*a[2] + c[0]*a[1]*b[2]
             - c[0]*b[1]*a[2] - b[0]*a[1]*c[2] - a[0]*c[1]*b[2];
    endfunction

    function automatic void divq(input big_t num, input big_t den, output int q, output bit ov);
        big_t an, ad, qq;
        an = (num < 0) ? -num : num;
        ad = (den < 0) ? -den : den;
        qq = (an <<< 16) / ad;
        ov = ((qq >>> 31) != 0);
        if ((num < 0) != (den < 0)) qq = -qq;
        q  = ov ? 0 : qq[31:0];
    endfunction

    function automatic void model(input int c[3][3], input int e[3], input int d[3], output exp_t x);
        big_t t1[3], t2[3], r[3], n[3], dt[4];
        bit ovf, oa, ob, ot;
        int qa, qb, qt;
        longint sum;
        for (int j = 0; j < 3; j++) begin
            t1[j] = big_t'(c[1][j]) - big_t'(c[0][j]);
            t2[j] = big_t'(c[2][j]) - big_t'(c[0][j]);
            r[j]  = big_t'(e[j]) - big_t'(c[0][j]);
            n[j]  = -big_t'(d[j]);
        end
        dt[0] = det_cols(t1, t2, n) >>> 32;
        dt[1] = det_cols(r, t2, n) >>> 32;
        dt[2] = det_cols(t1, r, n) >>> 32;
        dt[3] = det_cols(t1, t2, r) >>> 32;
        ovf = 0;
        for (int k = 0; k < 4; k++)
            if ((dt[k] >>> 31) != 0 && (dt[k] >>> 31) != -1) ovf = 1;
        x.hit = 0; x.a = 0; x.b = 0; x.t = 0; x.acc = 0;
        if (ovf || dt[0] == 0) begin
            x.inv = 1; x.chkv = 0; x.lat = 2;
            return;
        end
        divq(dt[1], dt[0], qa, oa);
        if (oa || qa < 0 || qa > ONE) begin
            x.inv = oa; x.chkv = !oa; x.a = qa; x.lat = W + 2;
            return;
        end
        divq(dt[2], dt[0], qb, ob);
        divq(dt[3], dt[0], qt, ot);
        x.inv  = ob || ot;
        x.chkv = !x.inv;
        x.a = qa; x.b = qb; x.t = qt;
        x.lat = 3*W + 2;
        sum = longint'(qa) + longint'(qb);
        x.hit = !x.inv && qb >= 0 && sum <= ONE && qt >= 0;
    endfunction

    task automatic send(input int c[3][3], input int e[3], input int d[3],
                        input bit push, input bit use_fixed, input exp_t fixed);
        exp_t x;
        int n = 0;
        while (!o_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout actual o_ready=0 required 1 (cycle %0d)", cyc);
            return;
        end
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) tri_i[k][j] = c[k][j];
        for (int j = 0; j < 3; j++) begin ray_i[1][j] = e[j]; ray_i[0][j] = d[j]; end
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) tri_i[k][j] = $urandom;
        for (int j = 0; j < 3; j++) begin ray_i[1][j] = $urandom; ray_i[0][j] = $urandom; end
        if (push) begin
            if (use_fixed) x = fixed;
            else model(c, e, d, x);
            x.acc = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every cycle of a presented result against the scoreboard entry.
    bit seen = 0, idle_chk = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0; idle_chk = 0;
        end else begin
            if (idle_chk) begin
                chk("idle_ready", o_ready, 1);
                chk("idle_valid", o_valid, 0);
                idle_chk = 0;
            end
            if (o_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result actual o_valid=1 required 0 (cycle %0d)", cyc);
                        cur.chkv = 0; cur.hit = o_hit; cur.inv = o_invalid;
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                    seen = 1;
                end
                chk("hit", o_hit, cur.hit);
                chk("invalid", o_invalid, cur.inv);
                if (cur.chkv) begin
                    chk("a", o_a, cur.a);
                    chk("b", o_b, cur.b);
                    chk("t", o_t, cur.t);
                end
                chk("busy_ready", o_ready, 0);
                if (i_ready) begin seen = 0; idle_chk = 1; end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      i_ready = 1'b1;
            else if (rdy_mode == 1) i_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c[3][3], e[3], d[3], p[3];
        exp_t fx;
        int kind, u, v, vcnt;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        tri_i = '0; ray_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_hit", o_hit, 0);
        chk("rst_invalid", o_invalid, 0);
        chk("rst_a", o_a, 0);
        chk("rst_b", o_b, 0);
        chk("rst_t", o_t, 0);
        rst = 1'b0;

        c = '{'{0, 0, 0}, '{ONE, 0, 0}, '{0, ONE, 0}};
        d = '{0, 0, -ONE};

        // basic hit
        e = '{16384, 16384, ONE};
        fx = '{hit: 1, inv: 0, chkv: 1, a: 16384, b: 16384, t: ONE, lat: 98, acc: 0};
        send(c, e, d, 1, 1, fx);
        drain();
        // in-plane of the triangle's bounding box but a+b > ONE
        e = '{49152, 49152, ONE};
        fx = '{hit: 0, inv: 0, chkv: 1, a: 49152, b: 49152, t: ONE, lat: 98, acc: 0};
        send(c, e, d, 1, 1, fx);
        drain();
        // early reject on a < 0
        e = '{-32768, 16384, ONE};
        fx = '{hit: 0, inv: 0, chkv: 1, a: -32768, b: 0, t: 0, lat: 34, acc: 0};
        send(c, e, d, 1, 1, fx);
        drain();
        // ray parallel to the triangle plane
        e = '{16384, 16384, ONE};
        d = '{ONE, 0, 0};
        fx = '{hit: 0, inv: 1, chkv: 1, a: 0, b: 0, t: 0, lat: 2, acc: 0};
        send(c, e, d, 1, 1, fx);
        drain();

        // result held under back-pressure
        d = '{0, 0, -ONE};
        rdy_mode = 2;
        @(negedge clk);
        i_ready = 1'b0;
        fx = '{hit: 1, inv: 0, chkv: 1, a: 16384, b: 16384, t: ONE, lat: 98, acc: 0};
        send(c, e, d, 1, 1, fx);
        vcnt = 0;
        while (!o_valid && vcnt < 200) begin @(posedge clk); #1; vcnt++; end
        chk("stall_valid_seen", o_valid, 1);
        repeat (10) begin @(posedge clk); #1; end
        i_ready = 1'b1;
        @(posedge clk); #1;
        rdy_mode = 0;
        drain();

        // reset during DIV_B discards the request
        send(c, e, d, 0, 0, fx);
        repeat (50) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_a", o_a, 0);
        vcnt = 0;
        repeat (120) begin @(posedge clk); #1; if (o_valid) vcnt++; end
        chk("midrst_no_result", vcnt, 0);
        send(c, e, d, 1, 1, fx);
        drain();

        // randomized rays with random result back-pressure
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++) c[k][j] = int'($urandom_range(0, 393216)) - 196608;
            for (int j = 0; j < 3; j++) e[j] = int'($urandom_range(0, 524288)) - 262144;
            if (kind == 0) begin
                for (int j = 0; j < 3; j++) d[j] = c[1][j] - c[0][j];
            end else if (kind == 1) begin
                for (int k = 0; k < 3; k++)
                    for (int j = 0; j < 3; j++) c[k][j] = $urandom;
                for (int j = 0; j < 3; j++) begin e[j] = $urandom; d[j] = $urandom; end
            end else begin
                u = int'($urandom_range(0, 81920)) - 8192;
                v = int'($urandom_range(0, 81920)) - 8192;
                for (int j = 0; j < 3; j++) begin
                    p[j] = c[0][j] + int'((longint'(u) * (c[1][j] - c[0][j]) +
                                           longint'(v) * (c[2][j] - c[0][j])) >>> 16);
                    d[j] = (kind == 2) ? e[j] - p[j] : p[j] - e[j];
                end
            end
            send(c, e, d, 1, 0, fx);
        end
        drain();
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_tri_intersect_iter.md
RAY_TRI_INTERSECT_ITER -- requirements
Module: ray_tri_intersect_iter

Interface
REQ-001 Parameter W, default 32, signed fixed-point word width of all vector components and results.
REQ-002 Parameter FRAC, default 16, fractional bits; ONE = 1<<FRAC.
REQ-003 Parameter MIN_T, default 0, smallest accepted t (Q format).
REQ-004 Parameter MAX_T, default 2^(W-1)-1, largest accepted t (Q format).
REQ-005 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  request valid.
REQ-008 o_ready  out  1  block can accept a request.
REQ-009 i_triangle  in  3x3xW signed  corners [2:0], components [2:0].
REQ-010 i_ray  in  2x3xW signed  [1] origin E, [0] direction D.
REQ-011 o_valid  out  1  result valid.
REQ-012 i_ready  in  1  consumer accepts result.
REQ-013 o_hit  out  1  ray hits triangle.
REQ-014 o_invalid  out  1  degenerate (coef==0) or arithmetic overflow.
REQ-015 o_a, o_b, o_t  out  W signed each  barycentric a, b and distance t.

Function
REQ-016 Request accepted on the edge where i_valid & o_ready; inputs registered then; inputs ignored otherwise.
REQ-017 Definitions: T1=C1-C0, T2=C2-C0, R=E-C0, N=-D, computed at W+1 bits (no wrap).
REQ-018 Determinants (columns): coef=det(T1,T2,N), det_a=det(R,T2,N), det_b=det(T1,R,N), det_t=det(T1,T2,R), full precision, then arithmetic shift right by 2*FRAC.
REQ-019 A shifted determinant not representable in W signed bits sets overflow.
REQ-020 Divider: one shared iterative restoring divider on magnitudes, W cycles per quotient, q=(|det_x|<<FRAC)/|coef|, truncated toward zero, sign = sign(det_x) xor sign(coef).
REQ-021 Division overflow when quotient magnitude needs more than W-1 bits.
REQ-022 FSM states: IDLE, DET, DIV_A, DIV_B, DIV_T, CHECK, DONE.
REQ-023 IDLE: o_ready=1; on accept -> DET.
REQ-024 DET: 1 cycle, registers determinants; -> CHECK if coef==0 or overflow, else -> DIV_A.
REQ-025 DIV_A (W cycles) -> CHECK if a<0 or a>ONE or overflow (early reject), else -> DIV_B.
REQ-026 DIV_B (W cycles) -> DIV_T; DIV_T (W cycles) -> CHECK.
REQ-027 CHECK: 1 cycle, computes flags, -> DONE.
REQ-028 o_hit=1 only if not invalid, a>=0, b>=0, a+b<=ONE (sum at W+1 bits), MIN_T<=t<=MAX_T.
REQ-029 o_invalid=1 if coef==0 or any determinant/division overflow; o_invalid forces o_hit=0.
REQ-030 Latency from accept edge to o_valid rising: 2 cycles degenerate/DET overflow, W+2 early reject, 3W+2 full.
REQ-031 Results not computed (skipped divisions) are driven 0.
REQ-032 DONE: o_valid=1, outputs stable until i_ready; on o_valid & i_ready -> IDLE; o_ready=0 in DONE (no same-cycle accept).
REQ-033 o_ready=0 in every state except IDLE.

Reset
REQ-034 i_rst has priority in any state: next state IDLE, o_valid=0, o_ready=1, o_hit=0, o_invalid=0, o_a=o_b=o_t=0, divider state cleared.
REQ-035 Request in progress when reset asserts is discarded; no result is produced for it.

Verification (W=32, FRAC=16, ONE=65536)
REQ-036 Tri (0,0,0),(1,0,0),(0,1,0); E=(0.25,0.25,1), D=(0,0,-1) -> o_valid at +98, o_hit=1, o_a=o_b=16384, o_t=65536, o_invalid=0.
REQ-037 Same tri, E=(0.75,0.75,1) -> o_valid at +98, o_hit=0, o_a=o_b=49152, o_invalid=0.
REQ-038 Same tri, E=(-0.5,0.25,1) -> early reject, o_valid at +34, o_hit=0, o_a=-32768, o_b=o_t=0.
REQ-039 Same tri, D=(1,0,0) -> coef=0, o_valid at +2, o_invalid=1, o_hit=0.
REQ-040 REQ-036 stimulus with i_ready low 10 cycles after o_valid -> outputs stable, o_ready=0 throughout, IDLE one cycle after i_ready high.
REQ-041 i_rst pulsed during DIV_B -> next cycle o_valid=0, o_ready=1; no result emitted; following request completes per REQ-036.
